dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the combined ARM/RISC-V pipeline's M stage.
//  It is the target end of the M-stage load/store request interface: it accepts
//  one request per valid/ready handshake and returns a single-cycle response after
//  a fixed, parameterised latency. Backing store is an internal word-organised RAM.
//  Not-ready time is fed to the hazard unit as a memory stall source.
// PARAMETERS
//  DEPTH_WORDS  1024  RAM size in 32-bit words (power of two)
//  LATENCY      2     cycles from accept edge to rsp_valid high (1..15)
//  BASE_ADDR    0     byte address of word 0 (word-aligned)
// PORTS
//  clk        in   1   clock, all logic on posedge
//  rst        in   1   synchronous reset, active-low
//  req_valid  in   1   M stage presents a request
//  req_ready  out  1   responder can accept this cycle
//  req_we     in   1   1 = store, 0 = load
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data, byte lanes per req_be
//  req_be     in   4   byte enables; lane i = bits [8i+7:8i]
//  rsp_valid  out  1   response valid, exactly one cycle per accepted request
//  rsp_rdata  out  32  load data; 0 for stores and errors
//  rsp_err    out  1   request faulted (qualified by rsp_valid)
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state IDLE, req_ready=1, rsp_valid=0,
//    rsp_rdata=0, rsp_err=0, latency counter=0. RAM contents not reset.
//  - Reset mid-operation: the pending request is dropped; a pending store is
//    NOT committed; no response is issued.
//  - Accept = req_valid & req_ready at posedge. Latch we/addr/wdata/be.
//  - FSM:
//    IDLE -> WAIT on accept.
//    WAIT: cnt counts LATENCY-1 down to 0; when cnt==0 -> RESP.
//    With LATENCY==1, accept goes directly to RESP.
//    RESP -> WAIT on accept in the same cycle (back-to-back); otherwise -> IDLE.
//  - req_ready = 1 in IDLE and RESP, 0 in WAIT.
//  - No response backpressure; the requester must consume rsp_valid.
//  - Throughput: one request per LATENCY cycles in back-to-back operation.
//  - Commit point: the RAM read and the store write both occur at the edge
//    entering RESP. Outputs are registered, so rsp_* appear that same cycle.
//  - Error check on latched request:
//    addr[1:0]!=0, addr<BASE_ADDR, or (addr-BASE_ADDR)>>2 >= DEPTH_WORDS.
//    On error: rsp_err=1, rsp_rdata=0, no RAM write.
//  - Load: rsp_rdata lane i = RAM lane i if be[i], else 8'h00.
//    be==0 returns 0, no error.
//  - Store: only lanes with be[i]=1 are written; rsp_rdata=0.
//    be==0 is a no-op, no error.
//  - Address arithmetic: word index = (addr-BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
//    Use 32-bit unsigned subtract; underflow is caught by the addr<BASE check.
//  - Read-after-write to the same word in consecutive requests returns the new
//    data; the store commits before the next read samples the RAM.
//  - rsp_valid, rsp_err, rsp_rdata return to 0 in any cycle not in RESP.
//  - req_* inputs are ignored when not accepted; values may change freely.
// TESTING
//  1. Reset: drive rst=0 for 2 cycles, then 1
//     -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//  2. Store then load, LATENCY=2: store 0x100, be=4'hF, data 0xDEADBEEF;
//     load 0x100, be=4'hF
//     -> each rsp_valid exactly 2 cycles after accept; load rdata=0xDEADBEEF.
//  3. Byte enables: word holds 0x11223344; store be=4'b0010, data 0x0000AA00;
//     load be=4'hF -> 0x1122AA44. Load be=4'b0001 -> 0x00000044.
//  4. Errors: load 0x102 -> rsp_err=1, rdata=0.
//     Store to BASE_ADDR+4*DEPTH_WORDS -> rsp_err=1, and a reload of word 0
//     shows no change.
//  5. Back-to-back: req_valid held high with 4 loads
//     -> accepts spaced LATENCY cycles apart, 4 rsp_valid pulses in order,
//     req_ready=0 during every WAIT cycle.
//  6. Reset mid-op: accept store to 0x200 with data 0x5A5A5A5A; assert rst=0
//     in the WAIT cycle -> no rsp_valid, and a later load of 0x200 returns the
//     old value.

Source files
------------

// File: rtl/dmem_responder.sv
// M-stage data-memory responder: valid/ready request port, fixed-latency single-cycle
// response, internal word RAM with byte-lane writes and address fault detection.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_commit;
  logic          w_c_we;
  logic [31:0]   w_c_addr;
  logic [31:0]   w_c_wdata;
  logic [3:0]    w_c_be;
  logic [31:0]   w_off;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rd;
  logic [31:0]   w_rmask;

  // With single-cycle latency the commit happens on the accept edge itself,
  // so the live request is used instead of the latched copy.
  always_comb begin
    w_accept  = req_valid && req_ready;
    w_commit  = 1'b0;
    w_c_we    = r_we;
    w_c_addr  = r_addr;
    w_c_wdata = r_wdata;
    w_c_be    = r_be;
    if (LATENCY == 1) begin
      w_commit  = w_accept;
      w_c_we    = req_we;
      w_c_addr  = req_addr;
      w_c_wdata = req_wdata;
      w_c_be    = req_be;
    end else begin
      w_commit  = (r_state == S_WAIT) && (r_cnt == 4'd1);
    end
    w_off   = w_c_addr - BASE_ADDR;
    w_err   = (w_off[1:0] != 2'b00) || (w_c_addr < BASE_ADDR) ||
              ((w_off >> 2) >= 32'(DEPTH_WORDS));
    w_idx   = w_off[AW+1:2];
    w_rd    = r_mem[w_idx];
    w_rmask = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (w_c_be[i]) w_rmask[8*i +: 8] = w_rd[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && w_commit && w_c_we && !w_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_c_be[i]) r_mem[w_idx][8*i +: 8] <= w_c_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= w_commit;
      rsp_err   <= w_commit && w_err;
      rsp_rdata <= (w_commit && !w_err && !w_c_we) ? w_rmask : '0;
      case (r_state)
        S_IDLE, S_RESP: begin
          if (w_accept) begin
            if (LATENCY == 1) begin
              r_state   <= S_RESP;
              req_ready <= 1'b1;
            end else begin
              r_state   <= S_WAIT;
              r_cnt     <= 4'(LATENCY - 1);
              req_ready <= 1'b0;
            end
          end else begin
            r_state   <= S_IDLE;
            req_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state   <= S_RESP;
            req_ready <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
